store_buffer: RTL and testbench

- Store-side counterpart of the load FU (fu_mem): the writer to the data BRAM that fu_mem reads.
- Accepts issued SW/SH/SB ops, computes address and byte strobes, and reports execution done to the ROB.
- Holds stores speculatively until the ROB commits them, then drains them in order to the data-memory write port.
- Uncommitted entries are flushed on mispredict.

---
 rtl/store_buffer_pkg.sv | 49 ++++
 rtl/store_buffer_strobe_gen.sv | 37 +++
 rtl/store_buffer.sv | 257 +++++++++++++++++++++++++
 tb/tb_store_buffer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: rs_data issue bundle, buffer entry,
// opcode/func3 constants, drain FSM state and the ROB flush-range helper.
package store_buffer_pkg;

  // ROB tag width carried inside the issue bundle and the buffer entries.
  localparam int TAG_W = 5;

  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic {
    DRAIN_IDLE  = 1'b0,
    DRAIN_WRITE = 1'b1
  } drain_state_t;

  // Subset of the reservation-station payload the store path consumes.
  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [31:0]      imm;
    logic [TAG_W-1:0] rob_index;
  } rs_data_t;

  typedef struct packed {
    logic             valid;
    logic             committed;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [2:0]       func3;
    logic [TAG_W-1:0] rob_tag;
  } sb_entry_t;

  // True when tag lies strictly between mis_tag and tail_tag going forward
  // around the ROB ring. Distances are taken from mis_tag so wrap-around
  // (e.g. mis=30, tail=2 -> 31, 0, 1) falls out of modular subtraction.
  function automatic logic in_flush_range(input logic [TAG_W-1:0] tag,
                                          input logic [TAG_W-1:0] mis_tag,
                                          input logic [TAG_W-1:0] tail_tag);
    logic [TAG_W-1:0] d_tag;
    logic [TAG_W-1:0] d_tail;
    d_tag  = tag - mis_tag;
    d_tail = tail_tag - mis_tag;
    return (d_tag != '0) && (d_tag < d_tail);
  endfunction

endpackage

// File: rtl/store_buffer_strobe_gen.sv
// sb_strobe_gen: turns an entry's func3 and low address bits into the byte
// strobes and the lane-replicated write data for the data-memory port.
module sb_strobe_gen
  import store_buffer_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata
);

  // Width decode: SW ignores addr_lo, SH uses bit 1 only, SB uses both bits.
  always_comb begin
    wstrb = 4'b0000;
    wdata = 32'h0;
    case (func3)
      F3_SW: begin
        wstrb = 4'b1111;
        wdata = data;
      end
      F3_SH: begin
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data[15:0]}};
      end
      F3_SB: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
      end
      default: begin
        wstrb = 4'b0000;
        wdata = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: holds issued stores until the ROB commits them, then drains
// them in order to the data-memory write port (one store per two cycles).
// Uncommitted stores younger than a mispredicted branch are discarded.
// Optional store-to-load forwarding port is built when STORE_FWD_EN is defined.
//
// Handshake: issued is a one-cycle request accepted only when the registered
// sb_full is low; store_done pulses one cycle after each accepted store;
// mem_we is a one-cycle write strobe with addr/wdata/wstrb valid alongside it.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ROB_W = TAG_W  // must equal TAG_W, the entry tag width
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issued,
  input  rs_data_t          data_in,
  input  logic [31:0]       ps1_data,
  input  logic [31:0]       ps2_data,
  input  logic              mispredict,
  input  logic [ROB_W-1:0]  mispredict_tag,
  input  logic [ROB_W-1:0]  curr_rob_tag,
  input  logic              commit_valid,
  input  logic [ROB_W-1:0]  commit_rob_tag,
`ifdef STORE_FWD_EN
  input  logic [31:0]       fwd_addr,
  output logic              fwd_hit,
  output logic [31:0]       fwd_data,
  output logic              fwd_stall,
`endif
  output logic              sb_full,
  output logic              store_done,
  output logic [ROB_W-1:0]  store_rob_tag,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  output drain_state_t      drain_state
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  sb_entry_t        entries   [DEPTH];
  sb_entry_t        entries_n [DEPTH];
  logic [PTR_W-1:0] slot      [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] tail_base;
  logic [PTR_W-1:0] tail_n;
  logic [PTR_W-1:0] head_n;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic [CNT_W-1:0] keep_cnt;

  drain_state_t     state;

  logic             pop;
  logic             alloc;
  logic             flush_any;
  logic             cm_found;
  logic             cm_hit;
  logic [PTR_W-1:0] cm_idx;

  logic [TAG_W-1:0] issue_tag;
  logic [TAG_W-1:0] mis_tag;
  logic [TAG_W-1:0] cur_tag;
  logic [TAG_W-1:0] cm_tag;

  logic [3:0]       head_wstrb;
  logic [31:0]      head_wdata;

  assign issue_tag   = data_in.rob_index;
  assign mis_tag     = TAG_W'(mispredict_tag);
  assign cur_tag     = TAG_W'(curr_rob_tag);
  assign cm_tag      = TAG_W'(commit_rob_tag);
  assign pop         = (state == DRAIN_WRITE);
  assign drain_state = state;

  // Physical slot of the i-th oldest entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot[i] = head + PTR_W'(i);
    end
  end

  // Write-port formatting for the entry at the head of the buffer.
  sb_strobe_gen u_strobe (
    .func3   (entries[head].func3),
    .addr_lo (entries[head].addr[1:0]),
    .data    (entries[head].data),
    .wstrb   (head_wstrb),
    .wdata   (head_wdata)
  );

  // Next-state for the entry array: commit marking, flush, pop and allocate.
  always_comb begin
    entries_n = entries;
    cm_found  = 1'b0;
    cm_idx    = head;
    cm_hit    = 1'b0;
    flush_any = 1'b0;
    keep_cnt  = count;
    alloc     = 1'b0;
    tail_base = tail;
    tail_n    = tail;
    head_n    = head;
    count_n   = count;

    // Commits arrive in program order, so only the oldest uncommitted entry
    // can match; anything else is a stray commit and is dropped.
    for (int i = 0; i < DEPTH; i++) begin
      if (!cm_found && (i < int'(count)) && entries[slot[i]].valid &&
          !entries[slot[i]].committed) begin
        cm_found = 1'b1;
        cm_idx   = slot[i];
      end
    end
    cm_hit = commit_valid && cm_found && (entries[cm_idx].rob_tag == cm_tag);

    // Flushed stores are always the youngest run, so the first hit from the
    // oldest end marks where the tail rolls back to. The head in WRITE and
    // anything committed (including by this cycle's commit) survives.
    if (mispredict) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!flush_any && (i < int'(count)) && entries[slot[i]].valid &&
            !entries[slot[i]].committed &&
            !(cm_hit && (slot[i] == cm_idx)) &&
            !(pop && (i == 0)) &&
            in_flush_range(entries[slot[i]].rob_tag, mis_tag, cur_tag)) begin
          flush_any = 1'b1;
          keep_cnt  = CNT_W'(i);
        end
      end
    end

    alloc = issued && !sb_full && (data_in.opcode == OP_STORE) &&
            !(mispredict && in_flush_range(issue_tag, mis_tag, cur_tag));

    tail_base = flush_any ? (head + PTR_W'(keep_cnt)) : tail;
    tail_n    = tail_base + (alloc ? PTR_W'(1) : PTR_W'(0));
    head_n    = pop ? (head + PTR_W'(1)) : head;
    count_n   = keep_cnt + (alloc ? CNT_W'(1) : CNT_W'(0)) -
                (pop ? CNT_W'(1) : CNT_W'(0));

    if (cm_hit) begin
      entries_n[cm_idx].committed = 1'b1;
    end

    if (flush_any) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((i >= int'(keep_cnt)) && (i < int'(count))) begin
          entries_n[slot[i]].valid = 1'b0;
        end
      end
    end

    if (pop) begin
      entries_n[head].valid     = 1'b0;
      entries_n[head].committed = 1'b0;
    end

    if (alloc) begin
      entries_n[tail_base].valid     = 1'b1;
      entries_n[tail_base].committed = 1'b0;
      entries_n[tail_base].addr      = ps1_data + data_in.imm;
      entries_n[tail_base].data      = ps2_data;
      entries_n[tail_base].func3     = data_in.func3;
      entries_n[tail_base].rob_tag   = issue_tag;
    end
  end

  // Buffer bookkeeping plus the registered full flag and execution-done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      sb_full       <= 1'b0;
      store_done    <= 1'b0;
      store_rob_tag <= '0;
    end else begin
      entries    <= entries_n;
      head       <= head_n;
      tail       <= tail_n;
      count      <= count_n;
      sb_full    <= (count_n == CNT_W'(DEPTH));
      store_done <= alloc;
      if (alloc) begin
        store_rob_tag <= ROB_W'(issue_tag);
      end
    end
  end

  // Drain FSM: launch the committed head store, then pop it the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= DRAIN_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'b0000;
    end else begin
      case (state)
        DRAIN_IDLE: begin
          if (entries[head].valid && entries[head].committed) begin
            // A store with an unknown width still drains, just without a write.
            mem_we    <= |head_wstrb;
            mem_addr  <= {entries[head].addr[31:2], 2'b00};
            mem_wdata <= head_wdata;
            mem_wstrb <= head_wstrb;
            state     <= DRAIN_WRITE;
          end
        end
        DRAIN_WRITE: begin
          mem_we <= 1'b0;
          state  <= DRAIN_IDLE;
        end
        default: begin
          mem_we <= 1'b0;
          state  <= DRAIN_IDLE;
        end
      endcase
    end
  end

`ifdef STORE_FWD_EN
  // Forwarding lookup: youngest full-word match supplies data; any sub-word
  // match to the same word cannot be merged here, so the load must stall.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_data  = 32'h0;
    fwd_stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((i < int'(count)) && entries[slot[i]].valid &&
          (entries[slot[i]].addr[31:2] == fwd_addr[31:2])) begin
        if (entries[slot[i]].func3 == F3_SW) begin
          fwd_hit  = 1'b1;
          fwd_data = entries[slot[i]].data;
        end else begin
          fwd_stall = 1'b1;
        end
      end
    end
    if (fwd_stall) begin
      fwd_hit  = 1'b0;
      fwd_data = 32'h0;
    end
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed stores, commits and flushes; a monitor
// compares every store_done and mem_we against queued expectations.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int ROB_W = 5;

  logic             clk;
  logic             reset;
  logic             issued;
  rs_data_t         data_in;
  logic [31:0]      ps1_data;
  logic [31:0]      ps2_data;
  logic             mispredict;
  logic [ROB_W-1:0] mispredict_tag;
  logic [ROB_W-1:0] curr_rob_tag;
  logic             commit_valid;
  logic [ROB_W-1:0] commit_rob_tag;
  logic             sb_full;
  logic             store_done;
  logic [ROB_W-1:0] store_rob_tag;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_wstrb;
  drain_state_t     drain_state;

  int checks = 0;
  int failures = 0;

  logic [ROB_W-1:0] exp_done_q[$];
  logic [67:0]      exp_mem_q[$];

  store_buffer #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .issued         (issued),
    .data_in        (data_in),
    .ps1_data       (ps1_data),
    .ps2_data       (ps2_data),
    .mispredict     (mispredict),
    .mispredict_tag (mispredict_tag),
    .curr_rob_tag   (curr_rob_tag),
    .commit_valid   (commit_valid),
    .commit_rob_tag (commit_rob_tag),
    .sb_full        (sb_full),
    .store_done     (store_done),
    .store_rob_tag  (store_rob_tag),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .drain_state    (drain_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every DUT output event must match the head of its queue.
  always @(negedge clk) begin
    if (reset) begin
      if (store_done) begin
        if (exp_done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL store_done_unexpected actual_tag=%0d expected=none", store_rob_tag);
        end else begin
          check("store_done_tag", 68'(store_rob_tag), 68'(exp_done_q.pop_front()));
        end
      end
      if (mem_we) begin
        if (exp_mem_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mem_we_unexpected actual_addr=0x%0h wdata=0x%0h wstrb=%b expected=none",
                   mem_addr, mem_wdata, mem_wstrb);
        end else begin
          check("mem_write", {mem_addr, mem_wdata, mem_wstrb}, exp_mem_q.pop_front());
        end
      end
    end
  end

  // Driver tasks: set_* arm inputs for the next posedge, step() applies them.
  task automatic set_issue(input logic [2:0] f3, input logic [31:0] base,
                           input logic [31:0] imm, input logic [31:0] wd,
                           input logic [ROB_W-1:0] tag, input bit expect_done);
    issued   = 1'b1;
    data_in  = '{opcode: OP_STORE, func3: f3, imm: imm, rob_index: tag};
    ps1_data = base;
    ps2_data = wd;
    if (expect_done) exp_done_q.push_back(tag);
  endtask

  task automatic set_commit(input logic [ROB_W-1:0] tag, input logic [67:0] exp_write);
    commit_valid   = 1'b1;
    commit_rob_tag = tag;
    exp_mem_q.push_back(exp_write);
  endtask

  task automatic set_mispredict(input logic [ROB_W-1:0] mtag, input logic [ROB_W-1:0] ctag);
    mispredict     = 1'b1;
    mispredict_tag = mtag;
    curr_rob_tag   = ctag;
  endtask

  task automatic step();
    @(negedge clk);
    issued       = 1'b0;
    commit_valid = 1'b0;
    mispredict   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_done_q.size() != 0 || exp_mem_q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check(name, 68'(exp_done_q.size() + exp_mem_q.size()), 68'(0));
  endtask

  initial begin
    reset          = 1'b0;
    issued         = 1'b0;
    data_in        = '0;
    ps1_data       = 32'h0;
    ps2_data       = 32'h0;
    mispredict     = 1'b0;
    mispredict_tag = '0;
    curr_rob_tag   = '0;
    commit_valid   = 1'b0;
    commit_rob_tag = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_sb_full", 68'(sb_full), 68'(0));
    check("reset_store_done", {store_done, store_rob_tag}, 68'(0));
    check("reset_mem_port", {mem_we, mem_addr, mem_wdata, mem_wstrb}, 68'(0));
    check("reset_drain_state", 68'(drain_state), 68'(DRAIN_IDLE));
    reset = 1'b1;
    @(negedge clk);

    // SW: addr 0x10, full word
    set_issue(F3_SW, 32'h0, 32'h10, 32'hDEADBEEF, 5'd3, 1'b1);
    step();
    check("sw_done_next_cycle", 68'(store_done), 68'(1));
    set_commit(5'd3, {32'h10, 32'hDEADBEEF, 4'b1111});
    step();
    wait_idle("sw_drain");

    // SB to byte 3, SH to upper half
    set_issue(F3_SB, 32'h13, 32'h0, 32'h000000AB, 5'd4, 1'b1);
    step();
    set_issue(F3_SH, 32'h10, 32'h2, 32'h00001234, 5'd5, 1'b1);
    step();
    set_commit(5'd4, {32'h10, 32'hABABABAB, 4'b1000});
    step();
    set_commit(5'd5, {32'h10, 32'h12341234, 4'b1100});
    step();
    wait_idle("sb_sh_drain");

    // Fill to capacity, rejected fifth issue, then free one slot
    set_issue(F3_SW, 32'h100, 32'h0, 32'h06060606, 5'd6, 1'b1); step();
    set_issue(F3_SW, 32'h104, 32'h0, 32'h07070707, 5'd7, 1'b1); step();
    set_issue(F3_SW, 32'h108, 32'h0, 32'h08080808, 5'd8, 1'b1); step();
    check("three_not_full", 68'(sb_full), 68'(0));
    set_issue(F3_SW, 32'h10C, 32'h0, 32'h09090909, 5'd9, 1'b1); step();
    check("four_full", 68'(sb_full), 68'(1));
    set_issue(F3_SW, 32'h200, 32'h0, 32'h0A0A0A0A, 5'd10, 1'b0); step();
    check("full_after_reject", 68'(sb_full), 68'(1));
    set_commit(5'd6, {32'h100, 32'h06060606, 4'b1111});
    step();
    step();
    step();
    check("not_full_after_write", 68'(sb_full), 68'(0));
    set_commit(5'd7, {32'h104, 32'h07070707, 4'b1111}); step();
    set_commit(5'd8, {32'h108, 32'h08080808, 4'b1111}); step();
    set_commit(5'd9, {32'h10C, 32'h09090909, 4'b1111}); step();
    wait_idle("full_drain");

    // Flush 4,5 while committing 2 in the same cycle
    set_issue(F3_SW, 32'h200, 32'h0, 32'h22222222, 5'd2, 1'b1); step();
    set_issue(F3_SW, 32'h204, 32'h0, 32'h44444444, 5'd4, 1'b1); step();
    set_issue(F3_SW, 32'h208, 32'h0, 32'h55555555, 5'd5, 1'b1); step();
    set_commit(5'd2, {32'h200, 32'h22222222, 4'b1111});
    set_mispredict(5'd3, 5'd8);
    step();
    wait_idle("flush_drain");
    // Buffer must be empty: next store commits and drains immediately
    set_issue(F3_SW, 32'h20C, 32'h0, 32'h88888888, 5'd8, 1'b1); step();
    set_commit(5'd8, {32'h20C, 32'h88888888, 4'b1111}); step();
    wait_idle("post_flush_drain");
    set_issue(F3_SW, 32'h210, 32'h0, 32'h99999999, 5'd9, 1'b1); step();
    set_issue(F3_SW, 32'h214, 32'h0, 32'hAAAAAAAA, 5'd10, 1'b1); step();
    set_issue(F3_SW, 32'h218, 32'h0, 32'hBBBBBBBB, 5'd11, 1'b1); step();
    check("post_flush_three_not_full", 68'(sb_full), 68'(0));
    set_issue(F3_SW, 32'h21C, 32'h0, 32'hCCCCCCCC, 5'd12, 1'b1); step();
    check("post_flush_four_full", 68'(sb_full), 68'(1));
    set_commit(5'd9,  {32'h210, 32'h99999999, 4'b1111}); step();
    set_commit(5'd10, {32'h214, 32'hAAAAAAAA, 4'b1111}); step();
    set_commit(5'd11, {32'h218, 32'hBBBBBBBB, 4'b1111}); step();
    set_commit(5'd12, {32'h21C, 32'hCCCCCCCC, 4'b1111}); step();
    wait_idle("refill_drain");

    // Wrap-around flush: 31 and 0 lie between 30 and 1
    set_issue(F3_SW, 32'h300, 32'h0, 32'h30303030, 5'd30, 1'b1); step();
    set_issue(F3_SW, 32'h304, 32'h0, 32'h31313131, 5'd31, 1'b1); step();
    set_issue(F3_SW, 32'h308, 32'h0, 32'h00000000, 5'd0, 1'b1); step();
    set_commit(5'd30, {32'h300, 32'h30303030, 4'b1111});
    set_mispredict(5'd30, 5'd1);
    step();
    wait_idle("wrap_flush_drain");

    // Reset during WRITE drops both committed stores
    set_issue(F3_SW, 32'h310, 32'h0, 32'h11111111, 5'd1, 1'b1); step();
    set_issue(F3_SW, 32'h314, 32'h0, 32'h12121212, 5'd2, 1'b1); step();
    commit_valid   = 1'b1;
    commit_rob_tag = 5'd1;
    step();
    commit_valid   = 1'b1;
    commit_rob_tag = 5'd2;
    @(posedge clk);
    #1;
    commit_valid = 1'b0;
    check("write_before_reset", 68'(mem_we), 68'(1));
    #1;
    reset = 1'b0;
    #1;
    check("reset_mid_write_we", 68'(mem_we), 68'(0));
    check("reset_mid_write_full", 68'(sb_full), 68'(0));
    check("reset_mid_write_state", 68'(drain_state), 68'(DRAIN_IDLE));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    wait_idle("after_reset_quiet");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
